calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 22 ++
 rtl/calc_sequencer_if.sv | 29 ++
 rtl/calc_flag_reg.sv | 31 +++
 rtl/calc_sequencer.sv | 143 ++++++++++++++
 tb/tb_calc_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the two-operand calculator sequencer.
// Holds the FSM state encoding, the ALU function codes and the default data width.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } calc_state_t;

    typedef logic [1:0] func_t;

    // The sequencer only carries these codes through to the ALU.
    localparam func_t FUNC_ADD = 2'b00;
    localparam func_t FUNC_SUB = 2'b01;
    localparam func_t FUNC_AND = 2'b10;
    localparam func_t FUNC_ORR = 2'b11;

endpackage

// File: rtl/calc_sequencer_if.sv
// Token-in / result-out handshake bundle between the sequencer and its neighbours.
// master = the producer/consumer side, slave = the sequencer itself.
interface calc_sequencer_if #(
    parameter int WIDTH = calc_pkg::DEFAULT_WIDTH
);
    import calc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    func_t            in_func;

    logic [WIDTH-1:0] res;
    logic [3:0]       NZCV;
    logic             V_sticky;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output in_valid, in_data, in_func, res_ready,
        input  in_ready, res, NZCV, V_sticky, res_valid
    );

    modport slave (
        input  in_valid, in_data, in_func, res_ready,
        output in_ready, res, NZCV, V_sticky, res_valid
    );

endinterface

// File: rtl/calc_flag_reg.sv
// Result flag store: NZCV captured with the result, plus a sticky overflow bit.
// clear drops only the sticky bit; NZCV keeps its last captured value.
module calc_flag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic       clear,
    input  logic [3:0] nzcv_d,
    output logic [3:0] nzcv,
    output logic       v_sticky
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzcv <= 4'b0000;
        end else if (capture) begin
            nzcv <= nzcv_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sticky <= 1'b0;
        end else if (clear) begin
            v_sticky <= 1'b0;
        end else if (capture && nzcv_d[0]) begin
            v_sticky <= 1'b1;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Collects operand A then B+Func, runs one ALU cycle, then holds res/NZCV until res_ready.
// Result is valid two cycles after the cycle that presents B; CALC_CHAIN_EN feeds res back as A.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    calc_sequencer_if.slave  io,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output func_t            Func,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_C,
    input  logic             alu_Z,
    input  logic             alu_N,
    input  logic             alu_V
);

    calc_state_t      state;
    calc_state_t      state_nxt;

    logic             in_ready;
    logic             res_valid;
    logic             load_a;
    logic             load_b;
    logic             capture;
    logic             a_from_res;

    logic [WIDTH-1:0] res_q;
    logic [3:0]       nzcv_q;
    logic             v_sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clr wins over every other transition, including a result handoff.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (io.in_valid) state_nxt = WAIT_B;
                WAIT_B:  if (io.in_valid) state_nxt = EXEC;
                EXEC:    state_nxt = DONE;
                DONE: begin
                    if (io.res_ready) begin
`ifdef CALC_CHAIN_EN
                        state_nxt = WAIT_B;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        capture    = 1'b0;
        a_from_res = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                load_a   = io.in_valid && !clr;
            end
            WAIT_B: begin
                in_ready = 1'b1;
                load_b   = io.in_valid && !clr;
            end
            EXEC: begin
                capture = !clr;
            end
            DONE: begin
                res_valid = 1'b1;
`ifdef CALC_CHAIN_EN
                a_from_res = io.res_ready && !clr;
`endif
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A <= '0;
        end else if (load_a) begin
            A <= io.in_data;
        end else if (a_from_res) begin
            A <= res_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            B    <= '0;
            Func <= FUNC_ADD;
        end else if (load_b) begin
            B    <= io.in_data;
            Func <= io.in_func;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else if (capture) begin
            res_q <= alu_out;
        end
    end

    calc_flag_reg u_flags (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .clear    (clr),
        .nzcv_d   ({alu_N, alu_Z, alu_C, alu_V}),
        .nzcv     (nzcv_q),
        .v_sticky (v_sticky_q)
    );

    assign io.in_ready  = in_ready;
    assign io.res_valid = res_valid;
    assign io.res       = res_q;
    assign io.NZCV      = nzcv_q;
    assign io.V_sticky  = v_sticky_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboarded bench for calc_sequencer with a combinational ALU model outside the DUT.
// Directed cases first, then randomized operations with random result back-pressure.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   nzcv;
        logic         sticky;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [W-1:0] A;
    logic [W-1:0] B;
    func_t        Func;
    logic [W-1:0] alu_out;
    logic         alu_C;
    logic         alu_Z;
    logic         alu_N;
    logic         alu_V;
    logic         v_inj;

    calc_sequencer_if #(.WIDTH(W)) io ();

    calc_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .io      (io),
        .A       (A),
        .B       (B),
        .Func    (Func),
        .alu_out (alu_out),
        .alu_C   (alu_C),
        .alu_Z   (alu_Z),
        .alu_N   (alu_N),
        .alu_V   (alu_V)
    );

    always #5 clk = ~clk;

    // ADD carry-out, SUB borrow in C; logic ops clear C.
    function automatic logic [W:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input func_t f);
        case (f)
            FUNC_ADD: return {1'b0, a} + {1'b0, b};
            FUNC_SUB: return {(a < b), a - b};
            FUNC_AND: return {1'b0, a & b};
            default:  return {1'b0, a | b};
        endcase
    endfunction

    always_comb begin
        {alu_C, alu_out} = ref_alu(A, B, Func);
        alu_N = alu_out[W-1];
        alu_Z = (alu_out == '0);
        alu_V = v_inj;
    end

    int           checks = 0;
    int           errors = 0;
    exp_t         q[$];
    exp_t         e;
    int           phase = 0;   // 0: next token is A, 1: next token is B, 2: result pending
    logic [W-1:0] m_a = '0;
    logic         m_sticky = 1'b0;
    int           rr_mode = 0; // 0: always ready, 1: random, 2: never ready
    logic         pv = 1'b0;
    logic [W-1:0] pres;
    logic [3:0]   pnzcv;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (rr_mode)
            0:       io.res_ready = 1'b1;
            1:       io.res_ready = 1'($urandom_range(0, 1));
            default: io.res_ready = 1'b0;
        endcase
    end

    // Monitor: hold-stability while stalled, pop-and-compare on each accepted result.
    always @(negedge clk) begin
        if (!rst && io.res_valid) begin
            chk("in_ready_low_in_done", 64'(io.in_ready), 64'd0);
            if (pv) begin
                chk("res_stable", 64'(io.res), 64'(pres));
                chk("nzcv_stable", 64'(io.NZCV), 64'(pnzcv));
            end
            if (io.res_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none", io.res);
                end else begin
                    e = q.pop_front();
                    chk("res", 64'(io.res), 64'(e.res));
                    chk("nzcv", 64'(io.NZCV), 64'(e.nzcv));
                    chk("v_sticky", 64'(io.V_sticky), 64'(e.sticky));
`ifdef CALC_CHAIN_EN
                    m_a   = e.res;
                    phase = 1;
`else
                    phase = 0;
`endif
                end
                pv = 1'b0;
            end else begin
                pv    = 1'b1;
                pres  = io.res;
                pnzcv = io.NZCV;
            end
        end else begin
            pv = 1'b0;
        end
    end

    task automatic wait_rdy();
        int n = 0;
        @(negedge clk);
        while (!io.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input func_t f, input bit with_clr, input bit chk_lat);
        bit           was_b;
        logic [W:0]   r;
        exp_t         x;
        wait_rdy();
        if (!io.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
            return;
        end
        io.in_valid = 1'b1;
        io.in_data  = d;
        io.in_func  = f;
        clr         = with_clr;
        was_b       = (phase == 1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.in_data  = W'($urandom);
        clr         = 1'b0;
        if (with_clr) begin
            phase    = 0;
            m_sticky = 1'b0;
        end else if (!was_b) begin
            m_a   = d;
            phase = 1;
            chk("a_load", 64'(A), 64'(d));
        end else begin
            r        = ref_alu(m_a, d, f);
            m_sticky = m_sticky | v_inj;
            x.res    = r[W-1:0];
            x.nzcv   = {r[W-1], (r[W-1:0] == '0), r[W], v_inj};
            x.sticky = m_sticky;
            q.push_back(x);
            phase    = 2;
            chk("b_load", 64'(B), 64'(d));
            chk("func_load", 64'(Func), 64'(f));
            if (chk_lat) begin
                chk("lat_exec_not_valid", 64'(io.res_valid), 64'd0);
                @(posedge clk);
                #1;
                chk("lat_done_valid", 64'(io.res_valid), 64'd1);
            end
        end
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input func_t f);
        wait_rdy();
        if (phase == 0) send(a, f, 1'b0, 1'b0);
        send(b, f, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        q.delete();
        phase    = 0;
        m_sticky = 1'b0;
        pv       = 1'b0;
        chk("clr_in_ready", 64'(io.in_ready), 64'd1);
        chk("clr_res_valid", 64'(io.res_valid), 64'd0);
        chk("clr_v_sticky", 64'(io.V_sticky), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(io.in_ready), 64'd1);
        chk({tag, "_res_valid"}, 64'(io.res_valid), 64'd0);
        chk({tag, "_A"}, 64'(A), 64'd0);
        chk({tag, "_B"}, 64'(B), 64'd0);
        chk({tag, "_func"}, 64'(Func), 64'd0);
        chk({tag, "_res"}, 64'(io.res), 64'd0);
        chk({tag, "_nzcv"}, 64'(io.NZCV), 64'd0);
        chk({tag, "_v_sticky"}, 64'(io.V_sticky), 64'd0);
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] b_prev;
        rst = 1'b0; clr = 1'b0; v_inj = 1'b0;
        io.in_valid = 1'b0; io.in_data = '0; io.in_func = FUNC_ADD;
        #2 rst = 1'b1;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 5 + 3, no back-pressure
        op(32'd5, 32'd3, FUNC_ADD);
        drain();
        chk("add_res", 64'(io.res), 64'd8);
        chk("add_nz", 64'(io.NZCV[3:2]), 64'd0);
        pulse_clr();

        // 3 - 5 held for four stalled cycles
        rr_mode = 2;
        op(32'd3, 32'd5, FUNC_SUB);
        repeat (4) @(negedge clk);
        chk("sub_res", 64'(io.res), 64'hFFFF_FFFE);
        chk("sub_nzcv", 64'(io.NZCV), 64'b1010);
        chk("sub_stalled_valid", 64'(io.res_valid), 64'd1);
        rr_mode = 0;
        drain();
        pulse_clr();

        // zero result
        op(32'd7, 32'd7, FUNC_SUB);
        drain();
        chk("zero_res", 64'(io.res), 64'd0);
        chk("zero_z", 64'(io.NZCV[2]), 64'd1);
        pulse_clr();

        // sticky overflow survives a later clean op, cleared by clr
        v_inj = 1'b1;
        op(32'd1, 32'd1, FUNC_ADD);
        v_inj = 1'b0;
        drain();
        op(32'd2, 32'd2, FUNC_ORR);
        drain();
        chk("sticky_held", 64'(io.V_sticky), 64'd1);
        chk("sticky_last_v", 64'(io.NZCV[0]), 64'd0);
        pulse_clr();

        // clr coincident with the B transfer
        b_prev = B;
        send(32'd9, FUNC_ADD, 1'b0, 1'b0);
        send(32'd4, FUNC_SUB, 1'b1, 1'b0);
        chk("clrb_b_held", 64'(B), 64'(b_prev));
        chk("clrb_a_held", 64'(A), 64'd9);
        repeat (3) begin
            @(negedge clk);
            chk("clrb_no_valid", 64'(io.res_valid), 64'd0);
            chk("clrb_idle", 64'(io.in_ready), 64'd1);
        end

        // rst in the middle of EXEC
        send(32'd6, FUNC_ADD, 1'b0, 1'b0);
        send(32'd7, FUNC_ADD, 1'b0, 1'b0);
        chk("exec_in_ready", 64'(io.in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        q.delete(); phase = 0; m_a = '0; m_sticky = 1'b0; pv = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // running total vs fresh A
        op(32'd2, 32'd3, FUNC_ADD);
        drain();
        chk("chain_first", 64'(io.res), 64'd5);
        send(32'd4, FUNC_ADD, 1'b0, 1'b1);
`ifdef CALC_CHAIN_EN
        drain();
        chk("chain_total", 64'(io.res), 64'd9);
`else
        repeat (3) begin
            @(negedge clk);
            chk("nochain_no_valid", 64'(io.res_valid), 64'd0);
        end
        chk("nochain_a", 64'(A), 64'd4);
`endif
        pulse_clr();

        // randomized operations with random back-pressure
        rr_mode = 1;
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = (i % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            rb = (i % 4 == 0) ? ra : W'($urandom);
            v_inj = ($urandom_range(0, 7) == 0);
            op(ra, rb, func_t'($urandom_range(0, 3)));
            v_inj = 1'b0;
        end
        rr_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
